// File: rtl/serial_adder.sv
// Bit-serial adder. One full-adder slice, built from two half-adder cells and
// an OR for the carry, is reused LSB-first across WIDTH cycles. The carry is
// registered between cycles. Operands come in and results go out through
// valid/ready handshakes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // A minimum of 1 keeps the counter legal in the degenerate WIDTH case.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Full-adder slice built from two half-adder cells.
    logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;
    logic last_bit;

    assign ha0_s    = a_q[0] ^ b_q[0];
    assign ha0_c    = a_q[0] & b_q[0];
    assign ha1_s    = ha0_s ^ c_q;
    assign ha1_c    = ha0_s & c_q;
    assign fa_c     = ha0_c | ha1_c;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Next-state logic: operand load, one bit per RUN cycle, result hold.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = src1;
                    b_d     = src2;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d = {ha1_s, sum_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = fa_c;
                if (last_bit) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset clears everything and aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = c_q;

endmodule
